// File: rtl/unibus_master.sv
// UNIBUS bus master: runs one DATI/DATO/DATOB cycle per request,
// with deskew setup/hold and a non-existent-memory timeout.
module unibus_master #(
  parameter int DESKEW  = 4,
  parameter int TIMEOUT = 'o2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write,
  input  logic        byte_op,
  input  logic [17:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        nxm,
  output logic [15:0] rdata,
  output logic [17:0] bus_addr_out,
  output logic [15:0] bus_d_out,
  output logic [1:0]  bus_c_out,
  output logic        bus_msyn_out,
  input  logic        bus_ssyn,
  input  logic [15:0] bus_d_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_MSYN,
    S_RELEASE,
    S_TAIL
  } state_e;

  localparam logic [15:0] SETUP_LAST = 16'(DESKEW);
  localparam logic [15:0] TAIL_LAST  = 16'(DESKEW - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 2);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nxm_q, nxm_d;
  logic        wr_q, wr_d;
  logic        msyn_q, msyn_d;
  logic [15:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [1:0]  c_q, c_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nxm_d   = nxm_q;
    wr_d    = wr_q;
    msyn_d  = msyn_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    c_d     = c_q;
    unique case (state_q)
      S_IDLE: begin
        // the done cycle itself never accepts
        if (req && !done_q) begin
          addr_d  = addr;
          dout_d  = write ? wdata : 16'h0;
          c_d     = write ? {1'b1, byte_op} : 2'b00;
          wr_d    = write;
          nxm_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 16'h0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          msyn_d  = 1'b1;
          cnt_d   = 16'h0;
          state_d = S_MSYN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_MSYN: begin
        if (bus_ssyn) begin
          if (!wr_q) rdata_d = bus_d_in;
          msyn_d  = 1'b0;
          dout_d  = 16'h0;
          state_d = S_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          nxm_d   = 1'b1;
          rdata_d = 16'h0;
          msyn_d  = 1'b0;
          dout_d  = 16'h0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RELEASE: begin
        if (!bus_ssyn) begin
          cnt_d   = 16'h0;
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = 18'h0;
          dout_d  = 16'h0;
          c_d     = 2'b00;
          wr_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nxm_q   <= 1'b0;
      wr_q    <= 1'b0;
      msyn_q  <= 1'b0;
      rdata_q <= 16'h0;
      addr_q  <= 18'h0;
      dout_q  <= 16'h0;
      c_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nxm_q   <= nxm_d;
      wr_q    <= wr_d;
      msyn_q  <= msyn_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      c_q     <= c_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign nxm          = nxm_q;
  assign rdata        = rdata_q;
  assign bus_addr_out = addr_q;
  assign bus_d_out    = dout_q;
  assign bus_c_out    = c_q;
  assign bus_msyn_out = msyn_q;

endmodule

// File: tb/tb_unibus_master.sv
// Bench for unibus_master: vector table of bus cycles with a
// completion scoreboard, plus reset and back-to-back sequences.
module tb_unibus_master;

  localparam int DSK = 3;
  localparam int TMO = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic        byte_op = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        bus_ssyn = 1'b0;
  logic [15:0] bus_d_in = '0;
  logic        busy, done, nxm, bus_msyn_out;
  logic [15:0] rdata, bus_d_out;
  logic [17:0] bus_addr_out;
  logic [1:0]  bus_c_out;

  unibus_master #(.DESKEW(DSK), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .write(write),
    .byte_op(byte_op),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .nxm(nxm),
    .rdata(rdata),
    .bus_addr_out(bus_addr_out),
    .bus_d_out(bus_d_out),
    .bus_c_out(bus_c_out),
    .bus_msyn_out(bus_msyn_out),
    .bus_ssyn(bus_ssyn),
    .bus_d_in(bus_d_in)
  );

  always #5 clk = ~clk;

  // k: cycles from msyn to slave ssyn; -1 means no slave
  typedef struct {
    logic        wr;
    logic        by;
    logic [17:0] a;
    logic [15:0] wd;
    int          k;
    logic [15:0] sd;
    logic        stale;
    logic [15:0] rd;
    logic        nx;
  } vec_t;

  typedef struct packed {
    logic [15:0] rd;
    logic        nx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0o required %0o",
                  nm, act, exp);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL sb_empty: got done, required no done");
    end else begin
      e = sb_q.pop_front();
      chk("sb_rdata", 32'(rdata), 32'(e.rd));
      chk("sb_nxm", 32'(nxm), 32'(e.nx));
    end
  endtask

  task automatic run(input vec_t v);
    int          j;
    int          hi;
    bit          ok;
    logic [1:0]  c;
    logic [15:0] ed;
    c  = v.wr ? {1'b1, v.by} : 2'b00;
    ed = v.wr ? v.wd : 16'h0;
    if (v.stale) begin
      bus_ssyn = 1'b1;
      repeat (3) @(negedge clk);
      chk("stale_idle", {busy, done}, 0);
      bus_ssyn = 1'b0;
    end
    write   = v.wr;
    byte_op = v.by;
    addr    = v.a;
    wdata   = v.wd;
    req     = 1'b1;
    sb_q.push_back('{rd: v.rd, nx: v.nx});
    @(negedge clk);
    req     = 1'b0;
    addr    = ~v.a;
    wdata   = ~v.wd;
    write   = ~v.wr;
    byte_op = ~v.by;
    chk("setup_busy", 32'(busy), 1);
    chk("setup_c", 32'(bus_c_out), 32'(c));
    chk("setup_d", 32'(bus_d_out), 32'(ed));
    ok = 1'b1;
    j  = 0;
    while (!bus_msyn_out && j <= DSK + 4) begin
      ok = ok & (bus_addr_out == v.a) &
           (bus_d_out == ed) & (bus_c_out == c);
      @(negedge clk);
      j++;
    end
    chk("msyn_rise", j, DSK + 1);
    hi = 0;
    while (bus_msyn_out && hi < TMO + 4) begin
      hi++;
      ok = ok & (bus_addr_out == v.a) &
           (bus_d_out == ed) & (bus_c_out == c);
      if (v.k >= 0 && hi == v.k + 1) begin
        bus_ssyn = 1'b1;
        bus_d_in = v.sd;
      end
      @(negedge clk);
    end
    chk("msyn_len", hi,
        (v.k >= 0 && v.k <= TMO - 2) ? v.k + 1 : TMO - 1);
    chk("rel_d", 32'(bus_d_out), 0);
    chk("rel_addr", 32'(bus_addr_out), 32'(v.a));
    chk("rel_c", 32'(bus_c_out), 32'(c));
    if (bus_ssyn) begin
      repeat (2) begin
        @(negedge clk);
        ok = ok & busy & !done & !bus_msyn_out &
             (bus_addr_out == v.a);
      end
      bus_ssyn = 1'b0;
      bus_d_in = 16'h0;
    end
    j = 0;
    while (!done && j < DSK + 6) begin
      @(negedge clk);
      j++;
      if (!done)
        ok = ok & (bus_addr_out == v.a) & (bus_c_out == c);
    end
    chk("tail_len", j, DSK + 1);
    if (done) sb_pop();
    chk("end_ctl", {busy, bus_msyn_out, bus_c_out}, 0);
    chk("end_bus", {bus_addr_out, bus_d_out[13:0]}, 0);
    chk("drive_stable", 32'(ok), 1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
  endtask

  vec_t vt[9];
  vec_t vr;

  initial begin
    int j;
    vt[0] = '{1'b0, 1'b0, 18'o773024, 16'o0, 5,
              16'o173000, 1'b0, 16'o173000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 18'o001000, 16'o123456, 2,
              16'o0, 1'b0, 16'o173000, 1'b0};
    vt[2] = '{1'b1, 1'b1, 18'o001001, 16'o000377, 0,
              16'o0, 1'b0, 16'o173000, 1'b0};
    vt[3] = '{1'b0, 1'b0, 18'o760000, 16'o0, -1,
              16'o0, 1'b0, 16'o0, 1'b1};
    vt[4] = '{1'b1, 1'b0, 18'o000001, 16'o177777, 3,
              16'o0, 1'b0, 16'o0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 18'o000002, 16'o0, 1,
              16'o052525, 1'b1, 16'o052525, 1'b0};
    vt[6] = '{1'b1, 1'b0, 18'o777776, 16'o000777, -1,
              16'o0, 1'b0, 16'o0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 18'o000100, 16'o0, TMO - 1,
              16'o007777, 1'b0, 16'o0, 1'b1};
    vt[8] = '{1'b0, 1'b0, 18'o000102, 16'o0, TMO - 2,
              16'o000123, 1'b0, 16'o000123, 1'b0};
    vr    = '{1'b0, 1'b0, 18'o000200, 16'o0, 2,
              16'o054321, 1'b0, 16'o054321, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, done, nxm, bus_msyn_out, bus_c_out}, 0);
    chk("rst_data", {rdata, bus_d_out}, 0);
    chk("rst_addr", 32'(bus_addr_out), 0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run(vt[i]);

    write   = 1'b0;
    byte_op = 1'b0;
    addr    = 18'o000777;
    req     = 1'b1;
    @(negedge clk);
    req = 1'b0;
    j = 0;
    while (!bus_msyn_out && j < DSK + 5) begin
      @(negedge clk);
      j++;
    end
    chk("rst_pre_msyn", 32'(bus_msyn_out), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_ctl",
        {busy, done, nxm, bus_msyn_out, bus_c_out}, 0);
    chk("rst_async_addr", 32'(bus_addr_out), 0);
    chk("rst_async_data", {rdata, bus_d_out}, 0);
    @(negedge clk);
    reset = 1'b1;
    run(vr);

    bus_d_in = 16'o011111;
    write    = 1'b0;
    addr     = 18'o000400;
    req      = 1'b1;
    sb_q.push_back('{rd: 16'o011111, nx: 1'b0});
    sb_q.push_back('{rd: 16'o011111, nx: 1'b0});
    j = 0;
    while (!done && j < 40) begin
      @(negedge clk);
      bus_ssyn = bus_msyn_out;
      j++;
    end
    chk("hold_done1", 32'(done), 1);
    if (done) sb_pop();
    @(negedge clk);
    bus_ssyn = bus_msyn_out;
    chk("hold_gap", 32'(busy), 0);
    @(negedge clk);
    bus_ssyn = bus_msyn_out;
    chk("hold_accept2", 32'(busy), 1);
    req = 1'b0;
    j = 0;
    while (!done && j < 40) begin
      @(negedge clk);
      bus_ssyn = bus_msyn_out;
      j++;
    end
    chk("hold_done2", 32'(done), 1);
    if (done) sb_pop();
    bus_ssyn = 1'b0;
    bus_d_in = 16'h0;
    @(negedge clk);

    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
